iram_arbiter: RTL
=================

Name: iram_arbiter

Overview:
- Shares the DW8051 internal data RAM (int_mem) between the core's iram port and one auxiliary requester, e.g. the IR receive engine depositing decoded frames.
- The core has absolute priority because it cannot stall. The aux port is served only in cycles where the core leaves the RAM idle.
- Sits between DW8051_core iram_* pins and int_mem; core-side signals pass through unchanged whenever the core is active.

Parameters:
- AW, 8, RAM address width
- DW, 8, RAM data width
- MAX_WAIT, 16, aux cycles spent pending before the starvation flag sets
- WCNT_W, 5, wait-counter width; must satisfy 2^WCNT_W > MAX_WAIT
- WIN_LO, 8'h30, lowest aux-writable address (protection feature only)
- WIN_HI, 8'h7F, highest aux-writable address (protection feature only)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- core_addr  in  AW  core iram_addr
- core_wdata  in  DW  core iram_data_in (write data)
- core_rd_n  in  1  core read strobe, active-low
- core_we1_n  in  1  core write strobe 1, active-low
- core_we2_n  in  1  core write strobe 2, active-low
- core_rdata  out  DW  read data to core; equals ram_rdata combinationally
- ram_addr  out  AW  to int_mem addr
- ram_wdata  out  DW  to int_mem data_in
- ram_rd_n  out  1  to int_mem rd_n
- ram_we1_n  out  1  to int_mem we1_n
- ram_we2_n  out  1  to int_mem we2_n
- ram_rdata  in  DW  from int_mem data_out (combinational read)
- aux_req  in  1  aux request; sampled only while aux_ready=1
- aux_we  in  1  1=write, 0=read
- aux_addr  in  AW  aux address
- aux_wdata  in  DW  aux write data
- aux_ready  out  1  high in IDLE; request accepted when aux_req&aux_ready
- aux_gnt  out  1  combinational; high during the cycle the aux access drives the RAM
- aux_done  out  1  one-cycle pulse the cycle after the grant
- aux_rdata  out  DW  read data, valid while aux_done=1 and held until the next read completes
- aux_err  out  1  one-cycle pulse with aux_done when a write was suppressed (feature only; else tied 0)
- starve  out  1  sticky starvation flag
- starve_clr  in  1  clears starve

Behaviour:
- core_busy = ~core_rd_n | ~core_we1_n | ~core_we2_n.
- FSM states:
  - IDLE: aux_ready=1. On aux_req, latch we/addr/wdata into the hold register and go to PEND.
  - PEND: aux_gnt = ~core_busy. On a granted cycle go to DONE; otherwise stay in PEND.
  - DONE: aux_done=1. Return to IDLE. A new request is accepted in the cycle after DONE, so minimum throughput is one access per 3 cycles.
- RAM mux, when aux_gnt=0: ram_* = core_* (pure pass-through, zero latency).
- RAM mux, when aux_gnt=1:
  - ram_addr = hold addr; ram_wdata = hold wdata.
  - Read access: ram_rd_n=0, both we high.
  - Write access: ram_rd_n=1, ram_we1_n=ram_we2_n=0.
- Aux read: ram_rdata is registered into aux_rdata at the granted edge.
- Latency: request accepted at cycle N; grant at N+1 at the earliest; aux_done at N+2 at the earliest.
- Core activity can never be displaced. If the core goes busy in the same cycle as a potential grant, the core wins and aux stays in PEND.
- Wait counter:
  - Cleared on entry to PEND.
  - Increments each PEND cycle with core_busy=1 and saturates at MAX_WAIT.
  - Reaching MAX_WAIT sets starve. The aux request still remains pending (never dropped).
- starve_clr clears starve. If the set and clear conditions occur in the same cycle, set wins.
- Reset values: FSM=IDLE, aux_ready=1 (from the following cycle), aux_gnt=0, aux_done=0, aux_err=0, aux_rdata=0, starve=0, wait counter=0, hold register=0.
- While rst=1: ram_rd_n, ram_we1_n, ram_we2_n forced 1; aux_ready=0.
- Reset mid-operation: a pending request is discarded with no aux_done. The requester must re-issue.

Optional Feature:
- Macro: IRAM_ARB_WPROT_EN.
- Defined:
  - Aux writes with hold addr < WIN_LO or > WIN_HI are suppressed: the grant cycle still occurs, but the we strobes stay high.
  - aux_err pulses together with aux_done.
  - Aux reads are unrestricted.
- Undefined: all aux writes proceed; aux_err is constant 0.

Test Plan:
- Core idle; aux write addr 8'h40 data 8'hA5 at cycle 0 -> aux_gnt at cycle 1 with ram_we1_n=ram_we2_n=0 and ram_addr=8'h40; aux_done at cycle 2. A following aux read of 8'h40 returns aux_rdata=8'hA5.
- Core_rd_n held low for 5 cycles during aux PEND -> ram_* follow core_* throughout, no aux_gnt. Grant occurs in the first core-idle cycle; core read data unaffected.
- Core busy for 20 consecutive cycles with aux pending, MAX_WAIT=16 -> starve=1 after the 16th busy cycle. Access completes when the core idles. starve_clr pulse -> starve=0.
- Assert rst while in PEND -> ram strobes high, no aux_done. aux_ready=1 the cycle after rst drops; all outputs at reset values.
- With IRAM_ARB_WPROT_EN: aux write to 8'h10 -> aux_done with aux_err=1 and RAM content unchanged. Aux write to 8'h7F -> performed, aux_err=0.
- Back-to-back aux reads with the core idle -> one completed access every 3 cycles, aux_rdata updated on each aux_done.

Source files
------------

// File: rtl/iram_arbiter.sv
// iram_arbiter: shares DW8051 int_mem between the core (absolute priority) and one aux requester; IRAM_ARB_WPROT_EN enables the aux write window
module iram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int MAX_WAIT = 16,
  parameter int WCNT_W = 5,
  parameter logic [AW-1:0] WIN_LO = 8'h30,
  parameter logic [AW-1:0] WIN_HI = 8'h7F
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_rd_n,
  input  logic          core_we1_n,
  input  logic          core_we2_n,
  output logic [DW-1:0] core_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_rd_n,
  output logic          ram_we1_n,
  output logic          ram_we2_n,
  input  logic [DW-1:0] ram_rdata,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_wdata,
  output logic          aux_ready,
  output logic          aux_gnt,
  output logic          aux_done,
  output logic [DW-1:0] aux_rdata,
  output logic          aux_err,
  output logic          starve,
  input  logic          starve_clr
);
  typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;
`ifdef IRAM_ARB_WPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  localparam logic [WCNT_W-1:0] WMAX = WCNT_W'(MAX_WAIT);
  localparam logic [WCNT_W-1:0] WSET = WCNT_W'(MAX_WAIT - 1);
  state_t state_q, state_d;
  logic hold_we_q, hold_we_d;
  logic [AW-1:0] hold_addr_q, hold_addr_d;
  logic [DW-1:0] hold_wdata_q, hold_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic err_q, err_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic starve_q, starve_d;
  logic core_busy, in_win, wr_ok, starve_set;
  assign core_busy = ~core_rd_n | ~core_we1_n | ~core_we2_n;
  assign core_rdata = ram_rdata;
  assign in_win = (hold_addr_q >= WIN_LO) && (hold_addr_q <= WIN_HI);
  assign wr_ok = ~PROT | in_win;
  assign aux_rdata = rdata_q;
  assign aux_err = PROT & aux_done & err_q;
  assign starve = starve_q;
  // next-state, RAM mux and handshake outputs; reset forces strobes high and hides the aux port
  always_comb begin
    state_d = state_q;
    hold_we_d = hold_we_q;
    hold_addr_d = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    wcnt_d = wcnt_q;
    starve_set = 1'b0;
    aux_ready = 1'b0;
    aux_gnt = 1'b0;
    aux_done = 1'b0;
    ram_addr = core_addr;
    ram_wdata = core_wdata;
    ram_rd_n = core_rd_n;
    ram_we1_n = core_we1_n;
    ram_we2_n = core_we2_n;
    case (state_q)
      IDLE: begin
        aux_ready = 1'b1;
        if (aux_req) begin
          hold_we_d = aux_we;
          hold_addr_d = aux_addr;
          hold_wdata_d = aux_wdata;
          wcnt_d = '0;
          state_d = PEND;
        end
      end
      PEND: begin
        aux_gnt = ~core_busy;
        if (core_busy) begin
          wcnt_d = (wcnt_q == WMAX) ? wcnt_q : wcnt_q + WCNT_W'(1);
          starve_set = wcnt_q >= WSET;
        end else begin
          state_d = DONE;
          ram_addr = hold_addr_q;
          ram_wdata = hold_wdata_q;
          ram_rd_n = hold_we_q;
          ram_we1_n = ~(hold_we_q & wr_ok);
          ram_we2_n = ~(hold_we_q & wr_ok);
          rdata_d = hold_we_q ? rdata_q : ram_rdata;
          err_d = hold_we_q & ~wr_ok;
        end
      end
      DONE: begin
        aux_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      aux_ready = 1'b0;
      aux_gnt = 1'b0;
      aux_done = 1'b0;
      ram_addr = core_addr;
      ram_wdata = core_wdata;
      ram_rd_n = 1'b1;
      ram_we1_n = 1'b1;
      ram_we2_n = 1'b1;
    end
    starve_d = starve_set | (starve_q & ~starve_clr);
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_we_q <= 1'b0;
      hold_addr_q <= '0;
      hold_wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      wcnt_q <= '0;
      starve_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_we_q <= hold_we_d;
      hold_addr_q <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      wcnt_q <= wcnt_d;
      starve_q <= starve_d;
    end
  end
endmodule
